// File: rtl/debounce_multi_if.sv
// Channel-side signal bundle for debounce_multi: raw inputs in, debounced levels and edge flags out.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] i;
  logic [N_CH-1:0] o;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            any_change;

  modport master (
    output i,
    input  o,
    input  rise,
    input  fall,
    input  any_change
  );

  modport slave (
    input  i,
    output o,
    output rise,
    output fall,
    output any_change
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser and stable-window counter on a shared tick.
// Define DEBOUNCE_MULTI_EDGE_EN to build the registered rise/fall/any_change flags (tied 0 otherwise).
module debounce_multi #(
  parameter int unsigned     N_CH        = 4,
  parameter int unsigned     N_CYCLES    = 100,
  parameter int unsigned     PRESCALE    = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] RESET_VAL   = '0
) (
  input logic             clk,
  input logic             rst,
  debounce_multi_if.slave bus
);

  localparam int unsigned CW = $clog2(N_CYCLES);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [N_CH-1:0] s;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = bus.i;
  end else begin : g_sync
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = bus.i;
      for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
        sync_d[st] = sync_q[st-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '{default: RESET_VAL};
      end else begin
        sync_q <= sync_d;
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PW'(PRESCALE - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  logic [CW-1:0]   ctr_q [N_CH];
  logic [CW-1:0]   ctr_d [N_CH];
  logic [N_CH-1:0] o_q, o_d;

  // A counter only advances while the synchronised input disagrees with the output;
  // any agreeing cycle restarts the window, so short glitches never reach the output.
  always_comb begin
    o_d   = o_q;
    ctr_d = ctr_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (s[k] == o_q[k]) begin
        ctr_d[k] = '0;
      end else if (tick) begin
        if (ctr_q[k] == CW'(N_CYCLES - 1)) begin
          o_d[k]   = s[k];
          ctr_d[k] = '0;
        end else begin
          ctr_d[k] = ctr_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      ctr_q <= '{default: '0};
      o_q   <= RESET_VAL;
    end else begin
      pre_q <= pre_d;
      ctr_q <= ctr_d;
      o_q   <= o_d;
    end
  end

  assign bus.o = o_q;

`ifdef DEBOUNCE_MULTI_EDGE_EN
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic            any_q, any_d;

  // Flags are registered alongside o_q so they line up with the first cycle of the new level.
  always_comb begin
    rise_d = o_d & ~o_q;
    fall_d = ~o_d & o_q;
    any_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.any_change = any_q;
`else
  assign bus.rise       = '0;
  assign bus.fall       = '0;
  assign bus.any_change = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: scoreboard of expected output changes (dut_a) plus a prescaled
// instance (dut_b) checked against its latency window. Edge expectations follow DEBOUNCE_MULTI_EDGE_EN.
module tb_debounce_multi;

`ifdef DEBOUNCE_MULTI_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  localparam int Lat = 6;  // SYNC_STAGES + N_CYCLES for dut_a

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debounce_multi_if #(.N_CH(4)) bus_a ();
  debounce_multi_if #(.N_CH(4)) bus_b ();

  debounce_multi #(
    .N_CH(4), .N_CYCLES(4), .PRESCALE(1), .SYNC_STAGES(2), .RESET_VAL(4'b0000)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  debounce_multi #(
    .N_CH(4), .N_CYCLES(4), .PRESCALE(3), .SYNC_STAGES(2), .RESET_VAL(4'b0000)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  typedef struct {
    int   due;
    int   ch;
    logic val;
  } ev_t;

  ev_t        sb[$];
  int         step;
  int         errors;
  int         checks;
  logic [3:0] exp_o, exp_rise, exp_fall;
  logic       exp_any;

  // Queue a change of dut_a channel ch to val, Lat edges after the input just driven.
  task automatic expect_change(input int ch, input logic val);
    ev_t e;
    e.due = step + Lat;
    e.ch  = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  // Advance to the next sampling point and pop any expected changes that are due now.
  task automatic cycle();
    @(negedge clk);
    step++;
    exp_rise = '0;
    exp_fall = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].due == step) begin
        if (sb[j].val && !exp_o[sb[j].ch]) exp_rise[sb[j].ch] = 1'b1;
        if (!sb[j].val && exp_o[sb[j].ch]) exp_fall[sb[j].ch] = 1'b1;
        exp_o[sb[j].ch] = sb[j].val;
        sb.delete(j);
      end
    end
    if (!EdgeEn) begin
      exp_rise = '0;
      exp_fall = '0;
    end
    exp_any = |(exp_rise | exp_fall);
  endtask

  task automatic clear_model();
    sb.delete();
    step     = 0;
    exp_o    = '0;
    exp_rise = '0;
    exp_fall = '0;
    exp_any  = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus_a.i   = '0;
    bus_b.i   = '0;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change, bus_b.o, bus_b.rise, bus_b.fall,
           bus_b.any_change} !== 26'd0) begin
        errors++;
        $display("FAIL reset_hold got a.o=%b a.r=%b a.f=%b a.any=%b b.o=%b want all zero",
                 bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change, bus_b.o);
      end
      checks++;
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL reset_release step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  task automatic test_prescale();
    int lat;
    lat = 0;
    bus_b.i[2] = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus_b.o[2]) lat = k;
      else if (bus_b.rise !== 4'b0000 || bus_b.any_change !== 1'b0) begin
        errors++;
        $display("FAIL prescale_early_pulse k=%0d got rise=%b any=%b want 0000/0",
                 k, bus_b.rise, bus_b.any_change);
      end
    end
    if (lat < 12 || lat > 14) begin
      errors++;
      $display("FAIL prescale_latency got %0d cycles want 12..14", lat);
    end
    checks++;
    if ({bus_b.o, bus_b.rise, bus_b.any_change} !== {4'b0100, {1'b0, EdgeEn, 2'b00}, EdgeEn}) begin
      errors++;
      $display("FAIL prescale_rise_cycle got o=%b r=%b a=%b want o=0100 r=%b a=%b",
               bus_b.o, bus_b.rise, bus_b.any_change, {1'b0, EdgeEn, 2'b00}, EdgeEn);
    end
    checks++;
    @(negedge clk);
    if ({bus_b.o, bus_b.rise, bus_b.any_change} !== {4'b0100, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL prescale_after got o=%b r=%b a=%b want o=0100 r=0000 a=0",
               bus_b.o, bus_b.rise, bus_b.any_change);
    end
    checks++;
    bus_b.i[2] = 1'b0;
  endtask

  task automatic test_step_rise();
    bus_a.i[0] = 1'b1;
    expect_change(0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cycle();
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL step_rise step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  task automatic test_glitch();
    bus_a.i[1] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      cycle();
      if (c == 2) bus_a.i[1] = 1'b0;
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL glitch step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  // A pulse exactly one window long is the shortest that must get through.
  task automatic test_min_window();
    bus_a.i[1] = 1'b1;
    expect_change(1, 1'b1);
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (c == 3) begin
        bus_a.i[1] = 1'b0;
        expect_change(1, 1'b0);
      end
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL min_window step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  task automatic test_independence();
    bus_a.i[2] = 1'b1;
    expect_change(2, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c < 12 && c % 2 == 1) bus_a.i[1] = ~bus_a.i[1];
      else if (c >= 12) bus_a.i[1] = 1'b0;
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL independence step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  task automatic test_simul_fall();
    bus_a.i = 4'b1001;
    expect_change(2, 1'b0);
    expect_change(3, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c == 9) begin
        bus_a.i = 4'b0000;
        expect_change(0, 1'b0);
        expect_change(3, 1'b0);
      end
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL simul_edge step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  task automatic test_reset_midcount();
    bus_a.i = 4'b0010;
    expect_change(1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (c == 7) bus_a.i = 4'b1011;  // channel 0 counter reaches 2 four edges later
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL midcount_pre step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
    rst = 1'b1;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) #1;
      else @(negedge clk);
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change, bus_b.o} !== 17'd0) begin
        errors++;
        $display("FAIL midcount_in_reset c=%0d got o=%b r=%b f=%b a=%b b.o=%b want all zero",
                 c, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change, bus_b.o);
      end
      checks++;
    end
    @(negedge clk);
    rst = 1'b0;
    expect_change(0, 1'b1);
    expect_change(1, 1'b1);
    expect_change(3, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cycle();
      if ({bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change} !==
          {exp_o, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL midcount_post step=%0d got o=%b r=%b f=%b a=%b want o=%b r=%b f=%b a=%b",
                 step, bus_a.o, bus_a.rise, bus_a.fall, bus_a.any_change,
                 exp_o, exp_rise, exp_fall, exp_any);
      end
      checks++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_prescale();
    test_step_rise();
    test_glitch();
    test_min_window();
    test_independence();
    test_simul_fall();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset SHALL exist.
REQ-002 Parameter N_CH, default 4, number of independent input channels (1..32).
REQ-003 Parameter N_CYCLES, default 100, stable ticks required before an output changes (>= 2).
REQ-004 Parameter PRESCALE, default 1, clock cycles per debounce tick (>= 1).
REQ-005 Parameter SYNC_STAGES, default 2, input synchroniser depth per channel (0 = bypass, else 2..4).
REQ-006 Parameter RESET_VAL, default all zeros, N_CH-bit value of o and synchroniser flops at reset.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 i  input  N_CH  raw, possibly asynchronous and glitchy channel inputs.
REQ-010 o  output  N_CH  debounced channel levels, registered.
REQ-011 rise  output  N_CH  one-cycle pulse per channel when o goes 0->1.
REQ-012 fall  output  N_CH  one-cycle pulse per channel when o goes 1->0.
REQ-013 any_change  output  1  registered OR of rise|fall, same cycle as the pulses.

Function
REQ-014 Each channel SHALL pass through SYNC_STAGES flops; s[k] denotes the last stage (i[k] directly when SYNC_STAGES=0).
REQ-015 A shared prescaler SHALL count 0..PRESCALE-1 and assert internal tick when at PRESCALE-1, then wrap to 0; PRESCALE=1 gives tick every cycle.
REQ-016 Each channel SHALL own a counter of width clog2(N_CYCLES); all channels share the single prescaler.
REQ-017 Any cycle with s[k]==o[k] SHALL clear ctr[k] to 0, regardless of tick.
REQ-018 With s[k]!=o[k] and tick high, ctr[k] SHALL increment, except when ctr[k]==N_CYCLES-1, where o[k] SHALL take s[k] and ctr[k] SHALL clear.
REQ-019 With s[k]!=o[k] and tick low, ctr[k] SHALL hold.
REQ-020 With PRESCALE=1, o[k] SHALL change exactly SYNC_STAGES+N_CYCLES cycles after a stable step on i[k]; with PRESCALE>1, latency SHALL lie between SYNC_STAGES+(N_CYCLES-1)*PRESCALE+1 and SYNC_STAGES+N_CYCLES*PRESCALE cycles.
REQ-021 A glitch on s[k] of any length shorter than the required stable window SHALL NOT change o[k].
REQ-022 Counters SHALL never exceed N_CYCLES-1 and SHALL never wrap.
REQ-023 rise[k]/fall[k] SHALL be high in exactly the first cycle o[k] shows its new value, and low otherwise.
REQ-024 Multiple channels changing on the same edge SHALL each pulse independently; any_change SHALL be a single-cycle high.
REQ-025 Channels SHALL be fully independent: activity on one SHALL NOT affect another's counter or latency.

Reset
REQ-026 While rst is high: o=RESET_VAL, synchroniser flops=RESET_VAL, all counters and the prescaler=0, rise=fall=0, any_change=0.
REQ-027 Reset asserted mid-count SHALL discard partial counts; after release, a channel whose input differs from RESET_VAL SHALL need the full REQ-020 latency.
REQ-028 No rise/fall/any_change pulse SHALL occur on reset assertion or release.

Configuration
REQ-029 Macro DEBOUNCE_MULTI_EDGE_EN defined: rise, fall and any_change SHALL be implemented as in REQ-023/024.
REQ-030 Macro DEBOUNCE_MULTI_EDGE_EN undefined: rise, fall, any_change SHALL be tied to 0, no edge flops SHALL be built, and o behaviour SHALL be unchanged.

Verification
REQ-031 N_CH=4, N_CYCLES=4, PRESCALE=1, SYNC=2: i[0] steps 0->1 at cycle 10 -> o[0]=1 from cycle 16, rise[0] high only cycle 16, any_change high only cycle 16.
REQ-032 Same config: i[1] high for 3 cycles then low -> o[1] stays 0, no pulses on any output.
REQ-033 PRESCALE=3, N_CYCLES=4: i[2] steps 0->1 -> o[2] rises within 12..14 cycles of the step; counter never exceeds 3.
REQ-034 i[0] and i[3] step 1->0 on the same edge from o=4'b1001 -> fall=4'b1001 for one cycle, any_change one cycle, o=4'b0000.
REQ-035 rst pulsed while ctr[0]=2 with i[0]=1 -> o=RESET_VAL immediately, no pulse; after release o[0] rises after full 6 cycles.
REQ-036 Build without DEBOUNCE_MULTI_EDGE_EN, rerun REQ-031 -> identical o, rise/fall/any_change constant 0.
